// File: rtl/key_debouncer_mc_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared types and helpers for the multi-channel key debouncer.
//   key_fsm_t : per-channel debounce state
//   max()     : constant helper used to size the shared timing counter
// -----------------------------------------------------------------------------
package debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_t;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_mc_if.sv
// -----------------------------------------------------------------------------
// key_debouncer_mc_if
// Bundles the raw key inputs and the per-key debounced outputs.
//   key_i              : raw, asynchronous key levels
//   key_state_o        : debounced state, 1 = pressed
//   key_pressed_stb_o  : one-cycle strobe on confirmed press
//   key_released_stb_o : one-cycle strobe on confirmed release
//   key_long_stb_o     : one-cycle long-press strobe, at most once per press
// master = the side driving the keys (board / bench), slave = the debouncer.
// -----------------------------------------------------------------------------
interface key_debouncer_mc_if #(
  parameter int unsigned KEYS_CNT = 4
);

  logic [KEYS_CNT-1:0] key_i;
  logic [KEYS_CNT-1:0] key_state_o;
  logic [KEYS_CNT-1:0] key_pressed_stb_o;
  logic [KEYS_CNT-1:0] key_released_stb_o;
  logic [KEYS_CNT-1:0] key_long_stb_o;

  modport master (
    output key_i,
    input  key_state_o,
    input  key_pressed_stb_o,
    input  key_released_stb_o,
    input  key_long_stb_o
  );

  modport slave (
    input  key_i,
    output key_state_o,
    output key_pressed_stb_o,
    output key_released_stb_o,
    output key_long_stb_o
  );

endinterface

// File: rtl/key_debouncer_mc_ch.sv
// -----------------------------------------------------------------------------
// debouncer_ch
// One debounce channel: 2-flop synchroniser, 4-state FSM with a shared
// glitch/long-press counter, and registered outputs.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   key_i               : raw key level (asynchronous)
//   key_state_o         : debounced state, 1 = pressed
//   key_pressed_stb_o   : press strobe
//   key_released_stb_o  : release strobe
//   key_long_stb_o      : long-press strobe
// A new level is accepted after exactly CLK_DELAY consecutive synchronised
// samples at that level; any opposite sample restarts the qualification.
// -----------------------------------------------------------------------------
module debouncer_ch
  import debouncer_pkg::*;
#(
  parameter int unsigned CLK_DELAY      = 5,
  parameter int unsigned LONG_DELAY     = 50,
  parameter int unsigned CNT_W          = 6,
  parameter bit          KEY_ACTIVE_LVL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic key_state_o,
  output logic key_pressed_stb_o,
  output logic key_released_stb_o,
  output logic key_long_stb_o
);

  localparam bit              LONG_EN     = (LONG_DELAY != 0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(CLK_DELAY - 1);
  // With long-press disabled the compare value is never used; keep it in range.
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_EN ? CNT_W'(LONG_DELAY - 1) : '0;

  logic [1:0]       sync_q;
  logic             act;
  key_fsm_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_done_q, long_done_d;
  logic             key_state_q, key_state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Synchroniser idles at the inactive level so reset never looks like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{~KEY_ACTIVE_LVL}};
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  // Normalise polarity: act = 1 means the key is at its pressed level.
  assign act = (sync_q[1] == KEY_ACTIVE_LVL);

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!act) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == GLITCH_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!act) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (LONG_EN && !long_done_q) begin
          if (cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        // Once the long strobe has fired the counter simply holds.
      end

      RELEASE_WAIT: begin
        if (act) begin
          // Bounce back to pressed: long timing restarts, long_done is kept so
          // a single physical press never yields a second long strobe.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == GLITCH_LAST) begin
          state_d     = RELEASED;
          cnt_d       = '0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    key_state_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign key_state_o        = key_state_q;
  assign key_pressed_stb_o  = press_q;
  assign key_released_stb_o = release_q;
  assign key_long_stb_o     = long_q;

endmodule

// File: rtl/key_debouncer_mc.sv
// -----------------------------------------------------------------------------
// key_debouncer_mc
// Multi-channel key debouncer. Converts time parameters to clock counts,
// rejects unusable settings at elaboration and instantiates one independent
// debouncer_ch per key.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus_if : key_debouncer_mc_if.slave (raw keys in, debounced state/strobes out)
// -----------------------------------------------------------------------------
module key_debouncer_mc
  import debouncer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ   = 50,
  parameter int unsigned GLITCH_TIME_NS = 2000,
  parameter int unsigned LONG_TIME_NS   = 1000000,
  parameter int unsigned KEYS_CNT       = 4,
  parameter bit          KEY_ACTIVE_LVL = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  key_debouncer_mc_if.slave        bus_if
);

  localparam int unsigned CLK_DELAY  = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int unsigned LONG_DELAY = LONG_TIME_NS * CLK_FREQ_MHZ / 1000;
  // One counter serves both the glitch window and the long-press hold.
  localparam int unsigned CNT_W      = $clog2(max(CLK_DELAY, LONG_DELAY) + 1);

  // The FSM needs at least two qualification cycles to tell a level from a glitch.
  if (CLK_DELAY < 2) begin : g_bad_glitch
    $error("key_debouncer_mc: glitch window shorter than 2 clock cycles");
  end
  if ((LONG_DELAY != 0) && (LONG_DELAY < 2)) begin : g_bad_long
    $error("key_debouncer_mc: long-press delay shorter than 2 clock cycles");
  end
  if (KEYS_CNT < 1) begin : g_bad_keys
    $error("key_debouncer_mc: at least one key channel is required");
  end

  for (genvar g = 0; g < KEYS_CNT; g++) begin : g_ch
    debouncer_ch #(
      .CLK_DELAY      (CLK_DELAY),
      .LONG_DELAY     (LONG_DELAY),
      .CNT_W          (CNT_W),
      .KEY_ACTIVE_LVL (KEY_ACTIVE_LVL)
    ) u_ch (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .key_i              (bus_if.key_i[g]),
      .key_state_o        (bus_if.key_state_o[g]),
      .key_pressed_stb_o  (bus_if.key_pressed_stb_o[g]),
      .key_released_stb_o (bus_if.key_released_stb_o[g]),
      .key_long_stb_o     (bus_if.key_long_stb_o[g])
    );
  end

endmodule

// File: doc/key_debouncer_mc.md
# key_debouncer_mc

Multi-channel key debouncer: the parametrised successor to the single-key debouncer. It takes `KEYS_CNT` raw, asynchronous mechanical key inputs. For each key it produces a debounced level plus one-cycle press, release and long-press strobes. It sits between board pins and the UI/control logic. Channels are fully independent and share only clock and reset.

## Interface
- `CLK_FREQ_MHZ`, 50: clock frequency, MHz.
- `GLITCH_TIME_NS`, 2000: required stable time before a level change is accepted.
- `LONG_TIME_NS`, 1000000: hold time, after press confirmation, that fires the long-press strobe; 0 disables long-press.
- `KEYS_CNT`, 4: number of channels, ≥1.
- `KEY_ACTIVE_LVL`, 0: raw level meaning "pressed" (0 = active-low buttons).

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `key_i`  in  KEYS_CNT  raw key inputs, asynchronous to `clk_i`.
- `key_state_o`  out  KEYS_CNT  debounced state, 1 = pressed, independent of `KEY_ACTIVE_LVL`.
- `key_pressed_stb_o`  out  KEYS_CNT  1-cycle strobe on confirmed press.
- `key_released_stb_o`  out  KEYS_CNT  1-cycle strobe on confirmed release.
- `key_long_stb_o`  out  KEYS_CNT  1-cycle strobe, at most once per press.

## Operation
- Derived constants:
  - `CLK_DELAY = GLITCH_TIME_NS*CLK_FREQ_MHZ/1000`.
  - `LONG_DELAY = LONG_TIME_NS*CLK_FREQ_MHZ/1000`.
  - Counter width is `$clog2(max(CLK_DELAY, LONG_DELAY)+1)`.
  - Elaboration error if `CLK_DELAY < 2`, or if `LONG_DELAY` is nonzero and below 2.
- Per channel:
  - 2-flop synchroniser; its output is normalised to `act` (1 = pressed level).
  - Then a 4-state FSM plus counter `cnt`.
- FSM states and transitions:
  - RELEASED:
    - `act` → PRESS_WAIT, `cnt`=1.
    - Otherwise `cnt`=0.
  - PRESS_WAIT:
    - `!act` → RELEASED, `cnt`=0, no strobe.
    - `act` and `cnt==CLK_DELAY-1` → PRESSED, `cnt`=0, press strobe.
    - Otherwise `cnt`++.
  - PRESSED:
    - `!act` → RELEASE_WAIT, `cnt`=1.
    - `act`, `!long_done`, `LONG_DELAY≠0`, `cnt==LONG_DELAY-1` → long strobe, `long_done`=1.
    - `act` and `!long_done` otherwise → `cnt`++.
    - With `long_done` set, `cnt` holds.
  - RELEASE_WAIT:
    - `act` → PRESSED, `cnt`=0; `long_done` is kept and the long timing restarts.
    - `!act` and `cnt==CLK_DELAY-1` → RELEASED, release strobe, `long_done`=0.
    - Otherwise `cnt`++.
- Acceptance rule: exactly `CLK_DELAY` consecutive synchronised samples at the new level are required; any opposite sample aborts and restarts.
- `key_state_o` is 1 in PRESSED and RELEASE_WAIT.
- All outputs are registered.
- Channels never interact. Any number of strobes may be asserted in the same cycle.
- Press and release strobes of one channel can never coincide. Long and press strobes of one channel can never coincide.

## Timing
- Reset (async assert, sync-safe deassert by the surrounding design):
  - Synchroniser flops load the inactive level.
  - FSM state = RELEASED, `cnt`=0, `long_done`=0.
  - All outputs 0.
- Reset mid-count discards the pending transition; no strobe follows reset release.
- Press latency: `key_i` becomes active and stays stable from sampling edge 0.
  - PRESS_WAIT is entered at edge 2.
  - Press strobe and `key_state_o` rise after edge `CLK_DELAY+1`.
  - Strobe falls after edge `CLK_DELAY+2`.
- Release latency is identical.
- Long strobe rises after edge `CLK_DELAY+1+LONG_DELAY`, counted from the same edge 0, for a clean hold.
- A glitch of `CLK_DELAY-1` or fewer synchronised cycles produces no output change.

## Structure
- Package `debouncer_pkg`:
  - `key_fsm_t` enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - `max()` function used for counter-width computation.
- Sub-module `debouncer_ch`: one channel (synchroniser, FSM, counter, registered outputs), taking `CLK_DELAY`, `LONG_DELAY`, `CNT_W`, `KEY_ACTIVE_LVL`.
- Top: derives constants, checks parameters, generate-loops `KEYS_CNT` instances.

## Test plan
Bench parameters: `CLK_FREQ_MHZ`=50, `GLITCH_TIME_NS`=100 (`CLK_DELAY`=5), `LONG_TIME_NS`=1000 (`LONG_DELAY`=50), `KEYS_CNT`=4, `KEY_ACTIVE_LVL`=0.
- Clean press: `key_i[0]` goes 1→0 before edge 0 → `key_pressed_stb_o[0]`=1 for exactly one cycle after edge 6, `key_state_o[0]`=1 from then on; other channels stay 0.
- Bounce: `key_i[1]` toggles with 4-cycle segments for 40 cycles, then holds 0 → no strobe during the bouncing; a single press strobe 7 edges after the last toggle.
- Long press: hold `key_i[2]`=0 for 200 cycles → press strobe after edge 6, long strobe after edge 56, no further long strobe; on release, one release strobe 7 edges later.
- Simultaneous: all four keys pressed on the same edge → four press strobes in the same cycle; release key 3 only → only bit 3 of the release strobe.
- Reset mid-operation: assert `rst_i` during PRESS_WAIT (key held) → all outputs 0 immediately. After release, with the key still held, a fresh press strobe arrives 7 edges after the first post-reset sampling edge.
- Disabled long-press (`LONG_TIME_NS`=0): 10000-cycle hold → no `key_long_stb_o` ever.
